// File: rtl/multiplier_if.sv
// Start/result bundle for the iterative multiplier.
// master drives requests, slave returns the registered product.
interface multiplier_if;
  logic        doMultiply;
  logic        signedMultiply;
  logic [31:0] operantA;
  logic [31:0] operantB;
  logic        ready;
  logic        carryOut;
  logic [31:0] productLow;
  logic [31:0] productHigh;

  modport master (
    output doMultiply,
    output signedMultiply,
    output operantA,
    output operantB,
    input  ready,
    input  carryOut,
    input  productLow,
    input  productHigh
  );

  modport slave (
    input  doMultiply,
    input  signedMultiply,
    input  operantA,
    input  operantB,
    output ready,
    output carryOut,
    output productLow,
    output productHigh
  );
endinterface

// File: rtl/multiplier.sv
// 32x32 sequential shift-add multiplier, signed/unsigned, 64-bit result.
// MULTIPLIER_EARLY_EXIT_EN: stop stepping once the multiplier is exhausted.
module multiplier (
  input logic   clock,
  input logic   reset,
  multiplier_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PREPARE,
    MULTIPLY,
    CORRECT
  } state_t;

  state_t      state_q, state_d;
  logic        sgn_q, sgn_d;
  logic        neg_q, neg_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rdy_q, rdy_d;
  logic        cout_q, cout_d;
  logic [63:0] prod_q, prod_d;

  logic [32:0] sum;
  logic [63:0] aligned;
  logic [63:0] result;

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b0;
    cout_d  = cout_q;
    prod_d  = prod_q;
    sum     = '0;
    aligned = '0;
    result  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.doMultiply) begin
          a_d     = bus.operantA;
          b_d     = bus.operantB;
          sgn_d   = bus.signedMultiply;
          neg_d   = bus.signedMultiply &
                    (bus.operantA[31] ^ bus.operantB[31]);
          state_d = PREPARE;
        end
      end

      PREPARE: begin
        // 0x80000000 negates to itself, read as unsigned magnitude
        if (sgn_q && a_q[31]) a_d = ~a_q + 32'd1;
        if (sgn_q && b_q[31]) b_d = ~b_q + 32'd1;
        acc_d   = '0;
        cnt_d   = 5'd31;
        state_d = MULTIPLY;
      end

      MULTIPLY: begin
        sum = {1'b0, acc_q[63:32]};
        if (b_q[0]) sum = sum + {1'b0, a_q};
        acc_d = {sum, acc_q[31:1]};
        b_d   = b_q >> 1;
        if (cnt_q == 5'd0) begin
          state_d = CORRECT;
`ifdef MULTIPLIER_EARLY_EXIT_EN
        end else if (b_d == 32'd0) begin
          state_d = CORRECT;
`endif
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      CORRECT: begin
`ifdef MULTIPLIER_EARLY_EXIT_EN
        // cnt_q holds the steps skipped by the early exit
        aligned = acc_q >> cnt_q;
`else
        aligned = acc_q;
`endif
        result = neg_q ? (~aligned + 64'd1) : aligned;
        prod_d = result;
        if (sgn_q)
          cout_d = result[63:32] != {32{result[31]}};
        else
          cout_d = result[63:32] != 32'd0;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      cout_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      cout_q  <= cout_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.ready       = rdy_q;
  assign bus.carryOut    = cout_q;
  assign bus.productLow  = prod_q[31:0];
  assign bus.productHigh = prod_q[63:32];

endmodule

// File: tb/tb_multiplier.sv
// Bench for multiplier: directed and random operands against
// an arithmetic reference, latency and handshake checks.
module tb_multiplier;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  multiplier_if bus ();

  multiplier dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] ref_prod(
    input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic ref_cout(
    input bit s, input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint lim;
    p   = ref_prod(s, a, b);
    lim = 64'sd2147483648;
    if (s) return (p >= lim) || (p < -lim);
    return ref_prod(s, a, b) >= 64'h1_0000_0000;
  endfunction

  function automatic int exp_lat(
    input bit s, input logic [31:0] b);
`ifdef MULTIPLIER_EARLY_EXIT_EN
    logic [31:0] mag;
    int hb;
    mag = (s && b[31]) ? -b : b;
    hb  = 0;
    for (int i = 0; i < 32; i++)
      if (mag[i]) hb = i;
    return 3 + hb + 1;
`else
    return 35 + 0 * int'(s) + 0 * int'(b[0]);
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] prod();
    return {bus.productHigh, bus.productLow};
  endfunction

  task automatic run_op(input bit s,
                        input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    bit seen;
    logic [63:0] p;
    p = ref_prod(s, a, b);
    @(negedge clock);
    bus.doMultiply     = 1'b1;
    bus.signedMultiply = s;
    bus.operantA       = a;
    bus.operantB       = b;
    @(posedge clock);
    #1 bus.doMultiply  = 1'b0;
    bus.operantA       = $urandom;
    bus.operantB       = $urandom;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clock);
      #1 n++;
      if (bus.ready) seen = 1'b1;
    end
    chk("latency", 64'(n + 1), 64'(exp_lat(s, b)));
    chk("product", prod(), p);
    chk("carry", 64'(bus.carryOut), 64'(ref_cout(s, a, b)));
    @(posedge clock);
    #1 chk("pulse", 64'(bus.ready), 64'd0);
    chk("hold", prod(), p);
  endtask

  task automatic back_to_back(input logic [31:0] a1,
                              input logic [31:0] b1,
                              input logic [31:0] a2,
                              input logic [31:0] b2);
    int n;
    int n1;
    int n2;
    n1 = -1;
    n2 = -1;
    @(negedge clock);
    bus.doMultiply     = 1'b1;
    bus.signedMultiply = 1'b0;
    bus.operantA       = a1;
    bus.operantB       = b1;
    @(posedge clock);
    #1 bus.operantA    = a2;
    bus.operantB       = b2;
    n = 0;
    while (n2 < 0 && n < 300) begin
      @(posedge clock);
      #1 n++;
      if (n1 >= 0 && n > n1 + 1 && n2 < 0) begin
        bus.doMultiply = n[0];
        bus.operantA   = $urandom;
        bus.operantB   = $urandom;
      end
      if (bus.ready) begin
        if (n1 < 0) begin
          n1 = n;
          chk("b2b_p1", prod(), ref_prod(1'b0, a1, b1));
          chk("b2b_c1", 64'(bus.carryOut),
              64'(ref_cout(1'b0, a1, b1)));
        end else begin
          n2 = n;
          bus.doMultiply = 1'b0;
          chk("b2b_p2", prod(), ref_prod(1'b0, a2, b2));
          chk("b2b_c2", 64'(bus.carryOut),
              64'(ref_cout(1'b0, a2, b2)));
        end
      end
    end
    bus.doMultiply = 1'b0;
    chk("b2b_lat1", 64'(n1 + 1), 64'(exp_lat(1'b0, b1)));
    chk("b2b_gap", 64'(n2 - n1), 64'(exp_lat(1'b0, b2)));
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit rs;
    errors = 0;
    checks = 0;
    reset              = 1'b0;
    bus.doMultiply     = 1'b0;
    bus.signedMultiply = 1'b0;
    bus.operantA       = '0;
    bus.operantB       = '0;
    repeat (3) @(posedge clock);
    #1 chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_carry", 64'(bus.carryOut), 64'd0);
    chk("rst_prod", prod(), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    run_op(1'b0, 32'h0000_0007, 32'h0000_0006);
    chk("dir_7x6", prod(), 64'h0000_0000_0000_002A);
    run_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0005);
    chk("dir_m3x5", prod(), 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000);
    chk("dir_min2", prod(), 64'h4000_0000_0000_0000);
    chk("dir_min2_c", 64'(bus.carryOut), 64'd1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("dir_max2", prod(), 64'hFFFF_FFFE_0000_0001);
    chk("dir_max2_c", 64'(bus.carryOut), 64'd1);
    run_op(1'b1, 32'h1234_5678, 32'h0000_0000);
    run_op(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000);

    for (int i = 0; i < 10; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i[0]) rb = -rb;
      run_op(rs, ra, rb);
    end

    back_to_back(32'h0000_1234, 32'h8000_0003,
                 32'hDEAD_BEEF, 32'hC000_0001);

    @(negedge clock);
    bus.doMultiply     = 1'b1;
    bus.signedMultiply = 1'b1;
    bus.operantA       = 32'h0000_0055;
    bus.operantB       = 32'h8765_4321;
    @(posedge clock);
    #1 bus.doMultiply = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    #1 chk("mid_rst_ready", 64'(bus.ready), 64'd0);
    chk("mid_rst_carry", 64'(bus.carryOut), 64'd0);
    chk("mid_rst_prod", prod(), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    run_op(1'b0, 32'd2, 32'd3);
    chk("post_rst_2x3", prod(), 64'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier.md
# multiplier

Multi-cycle 32×32 sequential shift-add multiplier for the or1300 execute stage. It is the counterpart to the core's iterative divider and shares that unit's start/ready handshake style. Supports signed and unsigned operands and produces a full 64-bit product plus an overflow flag for the 32-bit result. Shared-pipeline stall logic waits on `ready` exactly as it does for division.

## Interface
- No parameters.
- `clock` input 1: single clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-low reset (0 = reset).
- `doMultiply` input 1: start request; sampled only in IDLE.
- `signedMultiply` input 1: 1 = two's-complement operands, 0 = unsigned; sampled with `doMultiply`.
- `operantA` input 32: multiplicand; sampled with `doMultiply`.
- `operantB` input 32: multiplier; sampled with `doMultiply`.
- `ready` output 1: registered one-cycle completion pulse.
- `carryOut` output 1: registered overflow flag; 1 when the 64-bit product is not representable in 32 bits.
- `productLow` output 32: product bits [31:0].
- `productHigh` output 32: product bits [63:32].

## Operation
- States: IDLE, PREPARE, MULTIPLY, CORRECT.
- IDLE, `doMultiply`=1:
  - Capture operands and `signedMultiply`.
  - Record sign = A[31]^B[31] when signed, else 0.
  - Go to PREPARE.
  - `doMultiply`=0: stay in IDLE.
- PREPARE:
  - Replace each captured operand by its magnitude: negate when signed and bit31=1.
  - 0x80000000 maps to magnitude 0x80000000 as unsigned 32-bit.
  - Clear the 64-bit accumulator and load the step counter with 31.
  - Go to MULTIPLY.
- MULTIPLY, one step per cycle:
  - If multiplier LSB=1, add the multiplicand into accumulator[63:32] with a 33-bit add (the carry is kept).
  - Shift {carry, accumulator} right by 1.
  - Shift the multiplier right by 1.
  - When the counter reaches 0 (after 32 steps), go to CORRECT; otherwise decrement the counter.
- CORRECT:
  - If sign=1, the product = 64-bit two's-complement negation of the accumulator; otherwise the accumulator unchanged.
  - Compute `carryOut`:
    - signed: productHigh ≠ {32{productLow[31]}}
    - unsigned: productHigh ≠ 0
  - Register the product, `carryOut` and `ready`=1, then return to IDLE.
- Outputs hold their value until the next CORRECT state overwrites them.
- `doMultiply` asserted outside IDLE is ignored; no queuing.
- Reset asserted at any time, including mid-operation:
  - State goes to IDLE immediately.
  - `ready`=0, `carryOut`=0, `productLow`=0, `productHigh`=0.
  - The in-flight operation is discarded.

## Timing
- Let edge 0 be the edge that samples `doMultiply`=1 in IDLE.
  - Edge 1 enters MULTIPLY.
  - Edges 2..33 perform the 32 steps.
  - Edge 34 registers the results.
- `ready` is high during the cycle after edge 34, for exactly one cycle. Fixed latency is 35 cycles.
- The product and `carryOut` are valid in the same cycle as `ready`.
- `doMultiply` held high continuously:
  - A new operation is accepted on the first edge at which the state is IDLE, which is the edge ending the `ready` cycle.
  - Back-to-back throughput is one result per 35 cycles.
- No combinational path from any input to any output.

## Configuration
- `MULTIPLIER_EARLY_EXIT_EN` defined:
  - MULTIPLY also exits to CORRECT when the remaining shifted multiplier is 0 after the current step.
  - The accumulator is then aligned by an extra right shift by the remaining step count, using a barrel shift in the CORRECT cycle.
  - Latency becomes 3 + (index of the highest set bit of |B| + 1) cycles, minimum 4 (|B|=0 or 1).
  - Results are identical to the non-early-exit build.
- Macro not defined: the fixed 32-step, 35-cycle latency described above.

## Test plan
- Unsigned, A=0x0000_0007, B=0x0000_0006:
  - product 0x0000_0000_0000_002A, `carryOut`=0.
  - `ready` exactly 35 cycles after the start edge (or 6 cycles with `MULTIPLIER_EARLY_EXIT_EN`).
- Signed, A=0xFFFF_FFFD (−3), B=0x0000_0005:
  - product 0xFFFF_FFFF_FFFF_FFF1, `carryOut`=0.
- Signed, A=B=0x8000_0000:
  - product 0x4000_0000_0000_0000, `carryOut`=1.
- Unsigned, A=B=0xFFFF_FFFF:
  - product 0xFFFF_FFFE_0000_0001, `carryOut`=1.
- Back-to-back with `doMultiply` held high, operands changed each accepted start:
  - two `ready` pulses 35 cycles apart, each with correct results.
  - Pulses of `doMultiply` during a busy period do not change the results.
- Reset low at cycle 10 of an operation:
  - all outputs 0 immediately, state IDLE.
  - After release, a new 2×3 operation yields 6 with nominal latency.
